// File: rtl/multi_channel_interval_tracker.sv
// Multi-channel interval tracker: rolling timestamped history of tracked/corroborating
// signal pairs, answering req/ack look-back queries for the first interval after prev_end.
module multi_channel_interval_tracker #(
  parameter  int NUM_CHANNELS = 4,
  parameter  int DEPTH        = 16,
  parameter  int TIME_WIDTH   = 32,
  localparam int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int PW           = $clog2(DEPTH),
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [TIME_WIDTH-1:0]   time_i,
  input  logic [NUM_CHANNELS-1:0] tracked_i,
  input  logic [NUM_CHANNELS-1:0] corrob_i,
  input  logic                    query_valid,
  output logic                    query_ready,
  input  logic [CW-1:0]           query_chan,
  input  logic [LW-1:0]           query_len,
  input  logic                    end_upd_valid,
  input  logic [CW-1:0]           end_upd_chan,
  input  logic [TIME_WIDTH-1:0]   end_upd_time,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [TIME_WIDTH-1:0]   result_start,
  output logic [TIME_WIDTH-1:0]   result_end,
  output logic                    result_has_start,
  output logic                    result_has_end,
  output logic                    result_err
);

  typedef struct packed {
    logic [TIME_WIDTH-1:0]   ts;
    logic [NUM_CHANNELS-1:0] tracked;
    logic [NUM_CHANNELS-1:0] corrob;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e                  state_q, state_d;
  entry_t                  mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [LW-1:0]           count_q;
  logic [TIME_WIDTH-1:0]   prev_end_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] prev_end_valid_q;

  // Per-query scan context; the result registers double as the response payload.
  logic [CW-1:0]         chan_q, chan_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [TIME_WIDTH-1:0] pe_q, pe_d;
  logic                  pev_q, pev_d;
  logic                  has_start_q, has_start_d;
  logic [TIME_WIDTH-1:0] start_q, start_d;
  logic                  c0_q, c0_d;
  logic                  has_end_q, has_end_d;
  logic [TIME_WIDTH-1:0] end_q, end_d;
  logic [TIME_WIDTH-1:0] prev_ts_q, prev_ts_d;
  logic                  err_q, err_d;

  logic   accept, len_ok;
  entry_t cur;
  logic   cur_tr, cur_co;
  logic   start_hit, end_stop, end_tent, scan_done, scan_wr;

  assign accept = query_valid && (state_q == IDLE);
  assign len_ok = (query_len != '0) && (query_len <= count_q);

  // Entry under examination is read combinationally, so a write to the same slot
  // this cycle only lands at the edge and cannot disturb the scan.
  assign cur       = mem_q[rd_ptr_q];
  assign cur_tr    = cur.tracked[chan_q];
  assign cur_co    = cur.corrob[chan_q];
  assign start_hit = !has_start_q && cur_tr && (!pev_q || (cur.ts > pe_q));
  assign end_stop  = has_start_q && (!cur_tr || (c0_q && !cur_co));
  assign end_tent  = has_start_q && !end_stop && !c0_q && cur_co;
  assign scan_done = (rem_q == LW'(1)) || end_stop;
  assign scan_wr   = (state_q == SCAN) && scan_done && has_end_d;

  // NOTE: the history RAM carries no reset; count_q bounds every query, so stale
  // slots are never observed and the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (sample_en) mem_q[wr_ptr_q] <= '{ts: time_i, tracked: tracked_i, corrob: corrob_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (sample_en) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (count_q != LW'(DEPTH)) count_q <= count_q + LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = len_ok ? SCAN : RESP;
      SCAN:    if (scan_done) state_d = RESP;
      RESP:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    query_ready  = (state_q == IDLE);
    result_valid = (state_q == RESP);
  end

  always_comb begin
    chan_d      = chan_q;
    rem_d       = rem_q;
    rd_ptr_d    = rd_ptr_q;
    pe_d        = pe_q;
    pev_d       = pev_q;
    has_start_d = has_start_q;
    start_d     = start_q;
    c0_d        = c0_q;
    has_end_d   = has_end_q;
    end_d       = end_q;
    prev_ts_d   = prev_ts_q;
    err_d       = err_q;
    if (accept) begin
      chan_d      = query_chan;
      rem_d       = query_len;
      rd_ptr_d    = wr_ptr_q - query_len[PW-1:0];
      pe_d        = prev_end_q[query_chan];
      pev_d       = prev_end_valid_q[query_chan];
      has_start_d = 1'b0;
      start_d     = '0;
      c0_d        = 1'b0;
      has_end_d   = 1'b0;
      end_d       = '0;
      err_d       = !len_ok;
    end else if (state_q == SCAN) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      rem_d     = rem_q - LW'(1);
      prev_ts_d = cur.ts;
      if (start_hit) begin
        has_start_d = 1'b1;
        start_d     = cur.ts;
        c0_d        = cur_co;
      end
      // A terminating entry closes the interval at the previous sample; a
      // corroborating edge on an uncorroborated start only moves the end forward.
      if (end_stop) begin
        has_end_d = 1'b1;
        end_d     = prev_ts_q;
      end else if (end_tent) begin
        has_end_d = 1'b1;
        end_d     = cur.ts;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q      <= '0;
      rem_q       <= '0;
      rd_ptr_q    <= '0;
      pe_q        <= '0;
      pev_q       <= 1'b0;
      has_start_q <= 1'b0;
      start_q     <= '0;
      c0_q        <= 1'b0;
      has_end_q   <= 1'b0;
      end_q       <= '0;
      prev_ts_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      chan_q      <= chan_d;
      rem_q       <= rem_d;
      rd_ptr_q    <= rd_ptr_d;
      pe_q        <= pe_d;
      pev_q       <= pev_d;
      has_start_q <= has_start_d;
      start_q     <= start_d;
      c0_q        <= c0_d;
      has_end_q   <= has_end_d;
      end_q       <= end_d;
      prev_ts_q   <= prev_ts_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_end_valid_q <= '0;
    end else begin
      if (scan_wr)       prev_end_valid_q[chan_q]       <= 1'b1;
      if (end_upd_valid) prev_end_valid_q[end_upd_chan] <= 1'b1;
    end
  end

  // NOTE: the explicit update is the later non-blocking assignment, so it wins
  // over a same-cycle scan write to the same channel.
  always_ff @(posedge clk) begin
    if (scan_wr)       prev_end_q[chan_q]       <= end_d;
    if (end_upd_valid) prev_end_q[end_upd_chan] <= end_upd_time;
  end

  assign result_start     = start_q;
  assign result_end       = end_q;
  assign result_has_start = has_start_q;
  assign result_has_end   = has_end_q;
  assign result_err       = err_q;

endmodule

// File: tb/tb_multi_channel_interval_tracker.sv
// Directed bench for multi_channel_interval_tracker: illegal lengths, interval search,
// corroboration, wrap with concurrent sampling, end-update collision, reset and back-pressure.
module tb_multi_channel_interval_tracker;

  localparam int NC = 4;
  localparam int TW = 32;
  localparam int CW = 2;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [TW-1:0] time_i;
  logic [NC-1:0] tracked_i;
  logic [NC-1:0] corrob_i;
  logic          query_valid;
  logic          query_ready;
  logic [CW-1:0] query_chan;
  logic [LW-1:0] query_len;
  logic          end_upd_valid;
  logic [CW-1:0] end_upd_chan;
  logic [TW-1:0] end_upd_time;
  logic          result_valid;
  logic          result_ready;
  logic [TW-1:0] result_start;
  logic [TW-1:0] result_end;
  logic          result_has_start;
  logic          result_has_end;
  logic          result_err;

  int n_cmp = 0;
  int n_err = 0;

  multi_channel_interval_tracker #(.NUM_CHANNELS(NC), .DEPTH(16), .TIME_WIDTH(TW)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_en        (sample_en),
    .time_i           (time_i),
    .tracked_i        (tracked_i),
    .corrob_i         (corrob_i),
    .query_valid      (query_valid),
    .query_ready      (query_ready),
    .query_chan       (query_chan),
    .query_len        (query_len),
    .end_upd_valid    (end_upd_valid),
    .end_upd_chan     (end_upd_chan),
    .end_upd_time     (end_upd_time),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_start     (result_start),
    .result_end       (result_end),
    .result_has_start (result_has_start),
    .result_has_end   (result_has_end),
    .result_err       (result_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int ts, input logic [NC-1:0] tr, input logic [NC-1:0] co);
    sample_en = 1'b1;
    time_i    = TW'(ts);
    tracked_i = tr;
    corrob_i  = co;
    tick();
    sample_en = 1'b0;
    tracked_i = '0;
    corrob_i  = '0;
  endtask

  // Issues a query and waits (bounded) for the response; k = edges after accept.
  task automatic do_query(input int ch, input int len, output int k);
    check("query_ready_before", query_ready, 1);
    query_valid = 1'b1;
    query_chan  = CW'(ch);
    query_len   = LW'(len);
    tick();
    query_valid = 1'b0;
    k = 0;
    while (!result_valid && k < 100) begin
      tick();
      k++;
    end
    check("result_valid_seen", result_valid, 1);
  endtask

  task automatic consume();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    logic [NC-1:0] tr;
    logic [NC-1:0] co;

    rst           = 1'b1;
    sample_en     = 1'b0;
    time_i        = '0;
    tracked_i     = '0;
    corrob_i      = '0;
    query_valid   = 1'b0;
    query_chan    = '0;
    query_len     = '0;
    end_upd_valid = 1'b0;
    end_upd_chan  = '0;
    end_upd_time  = '0;
    result_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_query_ready", query_ready, 1);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_start", result_start, 0);
    check("rst_result_end", result_end, 0);
    check("rst_has_start", result_has_start, 0);
    check("rst_has_end", result_has_end, 0);
    check("rst_err", result_err, 0);

    // Illegal lengths: 3 stored, ask for 4; then ask for 0
    sample(1, 4'b0000, 4'b0000);
    sample(2, 4'b0000, 4'b0000);
    sample(3, 4'b0000, 4'b0000);
    do_query(0, 4, k);
    check("ill4_latency", k, 0);
    check("ill4_err", result_err, 1);
    check("ill4_has_start", result_has_start, 0);
    check("ill4_has_end", result_has_end, 0);
    consume();
    check("ill4_released", result_valid, 0);
    do_query(0, 0, k);
    check("ill0_err", result_err, 1);
    check("ill0_has_start", result_has_start, 0);
    consume();

    // Interval on ch0: tracked 0,1,1,1,0 at t=10..14
    sample(10, 4'b0000, 4'b0000);
    sample(11, 4'b0001, 4'b0000);
    sample(12, 4'b0001, 4'b0000);
    sample(13, 4'b0001, 4'b0000);
    sample(14, 4'b0000, 4'b0000);
    do_query(0, 5, k);
    check("ch0_latency", k, 5);
    check("ch0_err", result_err, 0);
    check("ch0_has_start", result_has_start, 1);
    check("ch0_start", result_start, 11);
    check("ch0_has_end", result_has_end, 1);
    check("ch0_end", result_end, 13);
    consume();
    do_query(0, 5, k);
    check("ch0_repeat_has_start", result_has_start, 0);
    check("ch0_repeat_has_end", result_has_end, 0);
    check("ch0_repeat_err", result_err, 0);
    consume();

    // Corroboration on ch2: tracked 20..25, corrob 20..22
    for (int t = 20; t <= 25; t++) sample(t, 4'b0100, (t <= 22) ? 4'b0100 : 4'b0000);
    do_query(2, 6, k);
    check("ch2_latency", k, 4);
    check("ch2_start", result_start, 20);
    check("ch2_end", result_end, 22);
    check("ch2_has_end", result_has_end, 1);
    consume();

    // Wrap: 40 samples (ts=100+i) on ch3, query 16 while sampling every cycle
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tr = ((i >= 5 && i <= 10) || (i >= 20 && i <= 22) || i >= 28) ? 4'b1000 : 4'b0000;
      co = (i == 30 || i == 31) ? 4'b1000 : 4'b0000;
      sample(100 + i, tr, co);
    end
    check("wrap_query_ready", query_ready, 1);
    query_valid = 1'b1;
    query_chan  = 2'd3;
    query_len   = 5'd16;
    tick();
    query_valid = 1'b0;
    k = 0;
    while (!result_valid && k < 100) begin
      sample_en = 1'b1;
      time_i    = TW'(200 + k);
      tracked_i = 4'b0000;
      corrob_i  = 4'b1111;
      tick();
      k++;
    end
    sample_en = 1'b0;
    tracked_i = '0;
    corrob_i  = '0;
    check("wrap_result_valid", result_valid, 1);
    check("wrap_has_start", result_has_start, 1);
    check("wrap_start", result_start, 128);
    check("wrap_has_end", result_has_end, 1);
    check("wrap_end", result_end, 131);
    consume();

    // End-update collision on ch1: scan reaches RESP with end=50 as end_upd writes 100
    do_reset();
    sample(40, 4'b0000, 4'b0000);
    sample(45, 4'b0010, 4'b0000);
    sample(50, 4'b0010, 4'b0000);
    sample(55, 4'b0000, 4'b0000);
    query_valid = 1'b1;
    query_chan  = 2'd1;
    query_len   = 5'd4;
    tick();
    query_valid = 1'b0;
    tick();
    tick();
    tick();
    end_upd_valid = 1'b1;
    end_upd_chan  = 2'd1;
    end_upd_time  = 32'd100;
    tick();
    end_upd_valid = 1'b0;
    check("coll_result_valid", result_valid, 1);
    check("coll_start", result_start, 45);
    check("coll_end", result_end, 50);
    consume();
    sample(60, 4'b0010, 4'b0000);
    sample(110, 4'b0010, 4'b0000);
    sample(120, 4'b0000, 4'b0000);
    do_query(1, 3, k);
    check("coll_after_start", result_start, 110);
    check("coll_after_end", result_end, 110);
    consume();

    // Reset during SCAN
    do_reset();
    for (int t = 0; t < 8; t++) sample(t, 4'b0000, 4'b0000);
    query_valid = 1'b1;
    query_chan  = 2'd0;
    query_len   = 5'd8;
    tick();
    query_valid = 1'b0;
    tick();
    check("scan_busy_ready", query_ready, 0);
    rst = 1'b1;
    #2;
    check("rst_async_valid", result_valid, 0);
    check("rst_async_ready", query_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", result_valid, 0);
    check("post_rst_ready", query_ready, 1);
    check("post_rst_has_start", result_has_start, 0);
    do_query(0, 1, k);
    check("post_rst_count_err", result_err, 1);
    consume();

    // Back-pressure: result held 5 cycles with result_ready low
    sample(300, 4'b0001, 4'b0000);
    sample(301, 4'b0001, 4'b0000);
    sample(302, 4'b0000, 4'b0000);
    do_query(0, 3, k);
    check("bp_latency", k, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", result_valid, 1);
      check("bp_hold_start", result_start, 300);
      check("bp_hold_end", result_end, 301);
    end
    consume();
    check("bp_done_valid", result_valid, 0);
    check("bp_done_ready", query_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
